mux_arb_reg: RTL and testbench

Parametrised N-channel arbitrating multiplexer with a registered output and valid/ready handshakes on every channel and on the output. It generalises the 4:1 select muxes: instead of an external `sel`, the block chooses the source itself, using fixed-priority or round-robin arbitration, and holds the chosen word until downstream accepts it. It sits between several producer channels and a single consumer path in the datapath.

---
 rtl/mux_arb_reg.sv | 91 +++++++++
 tb/tb_mux_arb_reg.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mux_arb_reg.sv
// N-channel arbitrating multiplexer with a registered output stage.
// Grants one valid channel per cycle (fixed priority or round robin) whenever the output register can load.
module mux_arb_reg #(
   parameter int NCH = 4,
   parameter int DW  = 8,
   parameter int SW  = $clog2(NCH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mode,
   input  logic [NCH*DW-1:0]   in_data,
   input  logic [NCH-1:0]      in_valid,
   output logic [NCH-1:0]      in_ready,
   output logic [DW-1:0]       out_data,
   output logic [SW-1:0]       out_sel,
   output logic                out_valid,
   input  logic                out_ready
);

   logic [DW-1:0] chan [NCH];
   logic [DW-1:0] data_p1;
   logic [SW-1:0] sel_p1;
   logic          vld_p1;
   logic [SW-1:0] last;

   logic          load;
   logic          accept;
   logic          gnt_any;
   logic [SW-1:0] gnt_idx;
   logic [SW:0]   cand;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      assign chan[i] = in_data[i*DW +: DW];
   end

   assign load   = ~vld_p1 | out_ready;
   assign accept = load & ~rst & gnt_any;

   // One extra bit on the candidate index lets last+1+k exceed NCH-1 before
   // folding back, so the wrap happens at NCH rather than at 2**SW.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int k = 0; k < NCH; k++) begin
         if (mode) begin
            cand = {1'b0, last} + (SW+1)'(k + 1);
         end else begin
            cand = (SW+1)'(k);
         end
         if (cand >= (SW+1)'(NCH)) begin
            cand = cand - (SW+1)'(NCH);
         end
         if (!gnt_any && in_valid[cand[SW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[SW-1:0];
         end
      end
   end

   always_comb begin
      in_ready = '0;
      if (accept) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   // Output register stage; last follows every accepted grant in either mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         sel_p1  <= '0;
         last    <= SW'(NCH - 1);
      end else if (load) begin
         if (gnt_any) begin
            vld_p1  <= 1'b1;
            data_p1 <= chan[gnt_idx];
            sel_p1  <= gnt_idx;
            last    <= gnt_idx;
         end else begin
            vld_p1  <= 1'b0;
         end
      end
   end

   assign out_data  = data_p1;
   assign out_sel   = sel_p1;
   assign out_valid = vld_p1;

endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg (NCH=4, DW=8): table vectors, hand-written corner sequences,
// then random stimulus against a queue-free behavioural arbiter model.
module tb_mux_arb_reg;

   localparam int NCH = 4;
   localparam int DW  = 8;
   localparam int SW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              mode;
   logic [NCH*DW-1:0] in_data;
   logic [NCH-1:0]    in_valid;
   logic [NCH-1:0]    in_ready;
   logic [DW-1:0]     out_data;
   logic [SW-1:0]     out_sel;
   logic              out_valid;
   logic              out_ready;

   int nvec = 0;
   int nfail = 0;

   // model state
   int m_valid, m_data, m_sel, m_last;

   mux_arb_reg #(.NCH(NCH), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic        m;
      logic [3:0]  v;
      logic [31:0] d;
      logic        rdy;
      logic [3:0]  eir;
      logic        eov;
      logic [7:0]  eod;
      logic [1:0]  eos;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic m, input logic [3:0] v,
                        input logic [31:0] d, input logic rdy);
      rst = r; mode = m; in_valid = v; in_data = d; out_ready = rdy;
      @(negedge clk);
   endtask

   // Which channel the rules say should be granted right now, or -1.
   function automatic int model_grant();
      if (rst) return -1;
      if (m_valid != 0 && !out_ready) return -1;
      for (int k = 0; k < NCH; k++) begin
         int c;
         c = mode ? (m_last + 1 + k) % NCH : k;
         if (in_valid[c]) return c;
      end
      return -1;
   endfunction

   task automatic tick();
      int g;
      g = model_grant();
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_data = 0; m_sel = 0; m_last = NCH - 1;
      end else if (m_valid == 0 || out_ready) begin
         if (g >= 0) begin
            m_valid = 1;
            m_data  = int'((in_data >> (DW * g)) & 32'hFF);
            m_sel   = g;
            m_last  = g;
         end else begin
            m_valid = 0;
         end
      end
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] eir, input logic eov,
                            input logic [7:0] eod, input logic [1:0] eos);
      check({tag, ".in_ready"},  32'(in_ready),  32'(eir));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(eov));
      check({tag, ".out_data"},  32'(out_data),  32'(eod));
      check({tag, ".out_sel"},   32'(out_sel),   32'(eos));
   endtask

   initial begin
      int g;
      logic [3:0] eir;

      tbl[0]  = '{1'b1, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      tbl[1]  = '{1'b1, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
      tbl[2]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
      tbl[3]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0};
      tbl[4]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA1, 2'd1};
      tbl[5]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA2, 2'd2};
      tbl[6]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA3, 2'd3};
      tbl[7]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0};
      tbl[8]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA1, 2'd1};
      tbl[9]  = '{1'b0, 1'b1, 4'hF, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA2, 2'd2};
      tbl[10] = '{1'b0, 1'b0, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA3, 2'd3};
      tbl[11] = '{1'b0, 1'b0, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};
      tbl[12] = '{1'b0, 1'b0, 4'hA, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA1, 2'd1};

      rst = 1'b1; mode = 1'b1; in_valid = 4'hF; in_data = '0; out_ready = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 0; m_data = 0; m_sel = 0; m_last = NCH - 1;

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].r, tbl[i].m, tbl[i].v, tbl[i].d, tbl[i].rdy);
         check_all($sformatf("tbl%0d", i), tbl[i].eir, tbl[i].eov, tbl[i].eod, tbl[i].eos);
         tick();
      end

      // backpressure: load 5C from channel 2, then stall three cycles
      drive(1'b0, 1'b0, 4'b0100, 32'h005C0000, 1'b1);
      check_all("bp_load", 4'b0100, 1'b1, 8'hA1, 2'd1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 4'hF, 32'h11223344, 1'b0);
         check_all($sformatf("bp_hold%0d", i), 4'b0000, 1'b1, 8'h5C, 2'd2);
         tick();
      end
      // release with round robin, last=2, only channel 2 valid: pop and reload same cycle
      drive(1'b0, 1'b1, 4'b0100, 32'h00D70000, 1'b1);
      check_all("bp_release", 4'b0100, 1'b1, 8'h5C, 2'd2);
      tick();
      drive(1'b0, 1'b1, 4'b0011, 32'h0000B1B0, 1'b1);
      check_all("wrap0", 4'b0001, 1'b1, 8'hD7, 2'd2);
      tick();
      drive(1'b0, 1'b1, 4'b0011, 32'h0000B1B0, 1'b1);
      check_all("wrap1", 4'b0010, 1'b1, 8'hB0, 2'd0);
      tick();
      drive(1'b0, 1'b1, 4'b0000, 32'h0000B1B0, 1'b1);
      check_all("idle0", 4'b0000, 1'b1, 8'hB1, 2'd1);
      tick();
      drive(1'b0, 1'b1, 4'b0000, 32'h0000B1B0, 1'b1);
      check_all("idle1", 4'b0000, 1'b0, 8'hB1, 2'd1);
      tick();

      // reset mid-stream with a held word
      drive(1'b0, 1'b1, 4'b0001, 32'h000000EE, 1'b1);
      check_all("pre_rst", 4'b0001, 1'b0, 8'hB1, 2'd1);
      tick();
      drive(1'b1, 1'b1, 4'hF, 32'h44332211, 1'b0);
      check_all("in_rst", 4'b0000, 1'b1, 8'hEE, 2'd0);
      tick();
      drive(1'b1, 1'b1, 4'hF, 32'h44332211, 1'b1);
      check_all("in_rst_rdy", 4'b0000, 1'b0, 8'h00, 2'd0);
      tick();
      drive(1'b0, 1'b1, 4'hF, 32'h44332211, 1'b1);
      check_all("post_rst", 4'b0001, 1'b0, 8'h00, 2'd0);
      tick();
      // single valid channel equal to last is granted after a full wrap
      drive(1'b0, 1'b1, 4'b0001, 32'h44332211, 1'b1);
      check_all("self_wrap", 4'b0001, 1'b1, 8'h11, 2'd0);
      tick();

      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
               4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 3) != 0));
         g = model_grant();
         eir = (g >= 0) ? 4'(1 << g) : 4'b0000;
         check_all($sformatf("rnd%0d", i), eir, 1'(m_valid), 8'(m_data), 2'(m_sel));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
